mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
Multi-cycle controller for the EX-stage multiply (ALU control code MUL). It detects a MUL issued to the ALU and runs an iterative shift-add multiply over several cycles. While it runs, it stalls the pipeline, then presents the low DATA_W bits of the product for one accepted cycle. It sits beside the ALU in EX. The EX result mux selects result when result_valid is high.

Parameters:
DATA_W, 32, operand/result width (power of two, ≥4)
MUL_CODE, 4'd8, ALU control code that triggers the sequencer
EARLY_EXIT, 1, 1 = finish once remaining multiplier bits are all zero; 0 = always DATA_W iterations

Ports:
clk  in  1  clock, all state on rising edge
arst  in  1  asynchronous active-high reset
ex_valid  in  1  EX stage holds a valid instruction
alu_control  in  4  ALU operation code from ALU control
operand_a  in  DATA_W  multiplicand
operand_b  in  DATA_W  multiplier
ex_hold  in  1  pipeline frozen by another cause; EX cannot retire this cycle
flush  in  1  synchronous kill of the EX instruction (branch/exception)
stall  out  1  freeze IF/ID/EX (combinational)
busy  out  1  FSM not IDLE (registered-state decode)
result_valid  out  1  result holds the finished product
result  out  DATA_W  low DATA_W bits of operand_a*operand_b

Behaviour:
- States: IDLE, RUN, DONE. State register, acc, mcand, mplier and cnt (clog2(DATA_W) bits) reset asynchronously to IDLE/0.
- Outputs in reset: stall=0, busy=0, result_valid=0, result=0.
- start = IDLE & ex_valid & (alu_control==MUL_CODE) & ~flush.
- IDLE:
  - On start: stall=1; load acc=0, mcand=operand_a, mplier=operand_b, cnt=0; go to RUN.
  - Otherwise stall=0.
  - Non-MUL codes are ignored.
- RUN (stall=1 every cycle):
  - If mplier[0], acc += mcand (mod 2^DATA_W).
  - Then mcand <<= 1, mplier >>= 1 (logical), cnt++.
  - Go to DONE when cnt==DATA_W-1, or when EARLY_EXIT and (mplier>>1)==0.
  - Operands are captured at start; input changes during RUN are ignored.
- DONE:
  - result_valid=1, result=acc, stall=0.
  - If ex_hold: stay in DONE with the result stable.
  - Else: go to IDLE. result_valid drops the next cycle; result keeps its last value.
  - DONE never restarts on the same instruction, even though ex_valid/MUL are still present.
- Latency, with start at cycle T:
  - RUN cycles = position of the highest set bit of operand_b + 1 (1 when operand_b==0); DATA_W when EARLY_EXIT=0.
  - DONE is at T+1+RUN cycles.
  - stall is high from T to the last RUN cycle inclusive.
- flush: highest priority after reset. From any state go to IDLE next cycle, result_valid=0. stall still follows the current-state rule in the flush cycle.
- Reset mid-operation: immediately to IDLE, all outputs 0; no partial result is visible.
- Back-to-back MULs: the second starts from IDLE the cycle after DONE retires (no overlap).
- Overflow: upper product bits are discarded; signed and unsigned give identical low bits.

Decomposition:
- Shared package/header: ALU op codes (AND/OR/ADD/SLL/SRL/SUB/SLT/MUL), state encoding localparams, DATA_W default.
- One natural sub-module: mul_datapath (acc/mcand/mplier/cnt registers plus adder, driven by load/step enables from the FSM). The FSM stays in mul_sequencer.

Test Plan:
- Basic: a=7, b=6, MUL, EARLY_EXIT=1 → stall high 4 cycles (T..T+3), DONE at T+4, result=42, result_valid for 1 cycle.
- Full length: a=0xFFFFFFFF, b=0xFFFFFFFF → 32 RUN cycles, DONE at T+33, result=0x00000001. Same stimulus with EARLY_EXIT=0 and b=1 → still 32 RUN cycles, result=a.
- Zero and non-MUL: b=0 → DONE at T+2, result=0. alu_control=ADD with ex_valid → stall=0, busy=0, no state change.
- Hold: ex_hold=1 for 3 cycles in DONE with a=5, b=9 → result_valid stays 1, result stays 45. Release → IDLE next cycle.
- Flush: flush at the 5th RUN cycle of a=3, b=0x80000000 → IDLE next cycle, result_valid never asserted. A new MUL 2*2 then yields 4.
- Reset: assert arst asynchronously mid-RUN (between clock edges) → stall, busy, result_valid and result all 0 immediately. After release, a=0x10000, b=0x10000 gives result=0.

Source files
------------

// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the EX-stage multi-cycle multiply sequencer:
// ALU operation codes, FSM state encoding and the default datapath width.
package mul_sequencer_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SLL = 4'd3,
    ALU_SRL = 4'd4,
    ALU_SUB = 4'd5,
    ALU_SLT = 4'd6,
    ALU_MUL = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_datapath.sv
// Shift-add multiply datapath: accumulator, shifting multiplicand/multiplier
// and iteration counter, sequenced by load/step enables from the FSM.
module mul_datapath
  import mul_sequencer_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int EARLY_EXIT = 1
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic [DATA_W-1:0] acc_next,
  output logic              last
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [CNT_W-1:0]  cnt;
  logic              early;

  // Next accumulator value and "this step is the final one" decode
  always_comb begin
    acc_next = acc;
    early    = 1'b0;
    last     = 1'b0;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end else begin
      acc_next = acc;
    end
    // Early exit looks ahead: nothing left to add once the shifted multiplier is zero
    if (EARLY_EXIT != 0) begin
      early = ((mplier >> 1) == '0);
    end else begin
      early = 1'b0;
    end
    last = (cnt == CNT_W'(DATA_W - 1)) || early;
  end

  // Operand capture on load, one shift-add iteration per step
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= operand_a;
      mplier <= operand_b;
      cnt    <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// EX-stage multiply controller: detects a MUL, stalls the pipeline while the
// shift-add datapath iterates, then presents the low product bits.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int          DATA_W     = DATA_W_DEF,
  parameter logic [3:0]  MUL_CODE   = ALU_MUL,
  parameter int          EARLY_EXIT = 1
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              ex_valid,
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              ex_hold,
  input  logic              flush,
  output logic              stall,
  output logic              busy,
  output logic              result_valid,
  output logic [DATA_W-1:0] result
);

  mul_state_e        state;
  logic              start;
  logic              step;
  logic              last;
  logic [DATA_W-1:0] acc_next;

  assign start        = (state == ST_IDLE) && ex_valid && (alu_control == MUL_CODE) && !flush;
  assign step         = (state == ST_RUN);
  assign busy         = (state != ST_IDLE);
  assign result_valid = (state == ST_DONE);

  mul_datapath #(
    .DATA_W     (DATA_W),
    .EARLY_EXIT (EARLY_EXIT)
  ) u_datapath (
    .clk       (clk),
    .arst      (arst),
    .load      (start),
    .step      (step),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .acc_next  (acc_next),
    .last      (last)
  );

  // Stall decode; gated by reset so a pending MUL cannot stall during reset
  always_comb begin
    stall = 1'b0;
    if (arst) begin
      stall = 1'b0;
    end else begin
      case (state)
        ST_IDLE: stall = start;
        ST_RUN:  stall = 1'b1;
        ST_DONE: stall = 1'b0;
        default: stall = 1'b0;
      endcase
    end
  end

  // Control FSM; result is captured on the final iteration so it never shows partial sums
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state  <= ST_IDLE;
      result <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (last) begin
            state  <= ST_DONE;
            result <= acc_next;
          end
        end
        ST_DONE: begin
          if (!ex_hold) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed self-checking bench for mul_sequencer (EARLY_EXIT=1 main instance,
// EARLY_EXIT=0 second instance for the fixed-length case).
module tb_mul_sequencer;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          arst;
  logic          ex_valid, ex_valid_ne;
  logic [3:0]    alu_control;
  logic [DW-1:0] operand_a, operand_b;
  logic          ex_hold, flush;
  logic          stall, busy, result_valid;
  logic [DW-1:0] result;
  logic          stall_ne, busy_ne, result_valid_ne;
  logic [DW-1:0] result_ne;

  int tests  = 0;
  int failed = 0;
  int n;

  always #5 clk = ~clk;

  mul_sequencer #(.DATA_W(DW), .MUL_CODE(4'd8), .EARLY_EXIT(1)) dut (
    .clk(clk), .arst(arst), .ex_valid(ex_valid), .alu_control(alu_control),
    .operand_a(operand_a), .operand_b(operand_b), .ex_hold(ex_hold), .flush(flush),
    .stall(stall), .busy(busy), .result_valid(result_valid), .result(result)
  );

  mul_sequencer #(.DATA_W(DW), .MUL_CODE(4'd8), .EARLY_EXIT(0)) dut_ne (
    .clk(clk), .arst(arst), .ex_valid(ex_valid_ne), .alu_control(alu_control),
    .operand_a(operand_a), .operand_b(operand_b), .ex_hold(ex_hold), .flush(flush),
    .stall(stall_ne), .busy(busy_ne), .result_valid(result_valid_ne), .result(result_ne)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a MUL, count RUN cycles, check DONE, optional hold, then retirement.
  task automatic run_mul(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] exp_res, input int exp_run, input int hold);
    int cnt;
    ex_valid = 1'b1; alu_control = 4'd8; operand_a = a; operand_b = b;
    #1;
    chk({tag, "_start_stall"}, 64'(stall), 64'd1);
    chk({tag, "_start_busy"}, 64'(busy), 64'd0);
    tick();
    ex_valid = 1'b0;
    operand_a = 32'hDEAD_BEEF; operand_b = 32'hFFFF_FFFF;
    cnt = 0;
    while (stall && cnt < 40) begin
      cnt++;
      tick();
    end
    chk({tag, "_run_cycles"}, 64'(cnt), 64'(exp_run));
    chk({tag, "_done_valid"}, 64'(result_valid), 64'd1);
    chk({tag, "_result"}, 64'(result), 64'(exp_res));
    for (int h = 0; h < hold; h++) begin
      ex_hold = 1'b1;
      tick();
      chk({tag, "_hold_valid"}, 64'(result_valid), 64'd1);
      chk({tag, "_hold_result"}, 64'(result), 64'(exp_res));
    end
    ex_hold = 1'b0;
    tick();
    chk({tag, "_retire_valid"}, 64'(result_valid), 64'd0);
    chk({tag, "_retire_busy"}, 64'(busy), 64'd0);
    chk({tag, "_retire_result"}, 64'(result), 64'(exp_res));
  endtask

  initial begin
    arst = 1'b1; ex_valid = 1'b0; ex_valid_ne = 1'b0; alu_control = 4'd0;
    operand_a = '0; operand_b = '0; ex_hold = 1'b0; flush = 1'b0;
    tick();
    tick();
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(result_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    #2 arst = 1'b0;
    tick();

    // Basic, full-length wrap and zero multiplier (back-to-back)
    run_mul("basic", 32'd7, 32'd6, 32'd42, 3, 0);
    run_mul("full", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32, 0);
    run_mul("zero", 32'd123, 32'd0, 32'd0, 1, 0);

    // Fixed-length instance: b=1 still takes DATA_W iterations
    ex_valid_ne = 1'b1; alu_control = 4'd8; operand_a = 32'hFFFF_FFFF; operand_b = 32'd1;
    #1;
    chk("ne_start_stall", 64'(stall_ne), 64'd1);
    tick();
    ex_valid_ne = 1'b0;
    n = 0;
    while (stall_ne && n < 40) begin
      n++;
      tick();
    end
    chk("ne_run_cycles", 64'(n), 64'd32);
    chk("ne_done_valid", 64'(result_valid_ne), 64'd1);
    chk("ne_result", 64'(result_ne), 64'hFFFF_FFFF);
    chk("ne_other_idle", 64'(busy), 64'd0);
    tick();
    chk("ne_retire_valid", 64'(result_valid_ne), 64'd0);

    // Non-MUL op is ignored
    ex_valid = 1'b1; alu_control = 4'd2; operand_a = 32'd4; operand_b = 32'd5;
    #1;
    chk("add_stall", 64'(stall), 64'd0);
    tick();
    chk("add_busy", 64'(busy), 64'd0);
    chk("add_valid", 64'(result_valid), 64'd0);
    chk("add_result", 64'(result), 64'd0);
    ex_valid = 1'b0;

    // Hold in DONE for 3 cycles
    run_mul("hold", 32'd5, 32'd9, 32'd45, 4, 3);

    // Flush in the 5th RUN cycle
    ex_valid = 1'b1; alu_control = 4'd8; operand_a = 32'd3; operand_b = 32'h8000_0000;
    tick();
    ex_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    flush = 1'b1;
    #1;
    chk("flush_cycle_stall", 64'(stall), 64'd1);
    chk("flush_cycle_busy", 64'(busy), 64'd1);
    tick();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_stall", 64'(stall), 64'd0);
    chk("flush_valid", 64'(result_valid), 64'd0);
    tick();
    chk("flush_valid_later", 64'(result_valid), 64'd0);
    run_mul("after_flush", 32'd2, 32'd2, 32'd4, 2, 0);

    // Asynchronous reset mid-RUN, between clock edges
    ex_valid = 1'b1; alu_control = 4'd8; operand_a = 32'd7; operand_b = 32'hFFFF_FFFF;
    tick();
    ex_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #3 arst = 1'b1;
    #1;
    chk("arst_stall", 64'(stall), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_valid", 64'(result_valid), 64'd0);
    chk("arst_result", 64'(result), 64'd0);
    #2 arst = 1'b0;
    tick();
    chk("post_rst_busy", 64'(busy), 64'd0);
    run_mul("wrap16", 32'h0001_0000, 32'h0001_0000, 32'd0, 17, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
